cla_sum_accum: RTL
==================

CLA_SUM_ACCUM -- requirements
Module: cla_sum_accum

Interface
REQ-001 SHALL have parameter N_TERMS, default 16, giving the number of adder sums accumulated per result (legal range 1..31).
REQ-002 SHALL have parameter ACC_W, default 20, giving the accumulator and result width (legal range >= 16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_sum and in_last are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a sum this cycle.
REQ-007 SHALL have port in_sum, input, 16 bits: unsigned sum from the upstream 15+15-bit CLA, with bit 15 as its carry-out.
REQ-008 SHALL have port in_last, input, 1 bit: the sum on in_sum terminates the current group early.
REQ-009 SHALL have port out_valid, output, 1 bit: out_acc and out_count hold a completed result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-011 SHALL have port out_acc, output, ACC_W bits: the accumulated total of the group.
REQ-012 SHALL have port out_count, output, 5 bits: the number of sums in the group (1..N_TERMS).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ACC and HOLD.
REQ-014 SHALL count an input transfer on any cycle where in_valid=1 and in_ready=1; a result transfer on any cycle where out_valid=1 and out_ready=1.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-016 In IDLE, on an input transfer, SHALL set acc to in_sum zero-extended to ACC_W and cnt to 1; it SHALL go to HOLD if in_last=1 or N_TERMS=1, otherwise to ACC.
REQ-017 In ACC, on an input transfer, SHALL set acc to (acc + zero-extended in_sum) mod 2^ACC_W and cnt to cnt+1; it SHALL go to HOLD if cnt+1=N_TERMS or in_last=1.
REQ-018 Cycles without an input transfer in IDLE or ACC SHALL leave acc, cnt and the state unchanged (bubbles are allowed).
REQ-019 Latency: if the final input transfer is at edge t, out_valid SHALL be 1 from the cycle after edge t, carrying the updated acc and cnt.
REQ-020 In HOLD, out_acc and out_count SHALL stay stable while out_ready=0.
REQ-021 On a result transfer, the block SHALL go to IDLE and clear acc and cnt to 0; the cycle of the result transfer SHALL NOT also accept an input (no bypass).
REQ-022 Outside HOLD, out_acc SHALL show the running acc and out_count the running cnt; consumers SHALL qualify both with out_valid.
REQ-023 Overflow: the accumulator SHALL wrap modulo 2^ACC_W with no saturation and no flag; with the defaults no wrap is reachable (16 x 65535 < 2^20).
REQ-024 in_last SHALL be ignored when there is no input transfer.
REQ-025 in_sum and in_last values SHALL be ignored while in_valid=0.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE with acc=0 and cnt=0; after that edge out_valid=0, out_acc=0, out_count=0 and in_ready=1.
REQ-027 rst SHALL take priority over any transfer on the same edge, and a reset mid-group (in ACC or HOLD) SHALL discard the partial or held result.

Verification
REQ-028 Full group: 16 back-to-back transfers of in_sum=0xFFFF, in_last=0 -> out_valid the cycle after the 16th transfer, out_acc=0xFFFF0, out_count=16, in_ready=0.
REQ-029 Early termination: sums 3, 5, 7 with in_last=1 on the 7 -> out_acc=15, out_count=3.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, no input consumed; then out_ready=1 -> IDLE, and the next input is accepted one cycle later.
REQ-031 Bubbles: sums 1, 2 and 4 with in_valid low for 1-3 cycles between them, in_last on the third -> out_acc=7, out_count=3.
REQ-032 Reset mid-group: after 5 sums of 100, assert rst for 1 cycle, then send 2 sums of 10 with in_last -> out_acc=20, out_count=2.
REQ-033 N_TERMS=1 build: a single transfer of in_sum=0x8000 -> HOLD immediately, out_acc=0x08000, out_count=1.

Source files
------------

// File: rtl/cla_sum_accum_if.sv
// Handshake bus between the upstream CLA, the sum accumulator and the result consumer.
interface cla_sum_accum_if #(
    parameter int unsigned ACC_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_sum;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [4:0]       out_count;

    // Accumulator side
    modport slave (
        input  in_valid, in_sum, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_sum, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count
    );
endinterface

// File: rtl/cla_sum_accum.sv
// Accumulates groups of up to N_TERMS CLA sums and holds each group total until the consumer takes it.
module cla_sum_accum #(
    parameter int unsigned N_TERMS = 16,
    parameter int unsigned ACC_W   = 20
) (
    input  logic             clk,
    input  logic             rst,
    cla_sum_accum_if.slave   bus
);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    // State, datapath and handshake flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state and next accumulator/count
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    acc_d   = ACC_W'(bus.in_sum);
                    cnt_d   = CNT_W'(1);
                    state_d = (bus.in_last || (N_TERMS == 1)) ? ST_HOLD : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_xfer) begin
                    acc_d = acc_q + ACC_W'(bus.in_sum);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.in_last || ((cnt_q + CNT_W'(1)) == CNT_W'(N_TERMS))) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_xfer) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the next state so they leave a flop
    always_comb begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (state_d == ST_HOLD) begin
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_count = cnt_q;
endmodule
